alu_exec_stage: RTL and testbench
=================================

// Module: alu_exec_stage
// PURPOSE
//  Execute stage directly downstream of the ALU controller in the single-cycle MIPS datapath.
//  Takes the decoded ALUType::alu_cmd_t plus two operands and a destination register, and computes the result.
//  Registers the result with flags behind a valid/ready handshake, using a 2-entry skid buffer so backpressure never drops a result.
//  Keeps saturating op and overflow counters for debug.
// PARAMETERS
//  WIDTH      32  operand/result width in bits
//  CNT_WIDTH  16  width of each statistics counter
// PORTS
//  clk          in   1          clock, all state on rising edge
//  rst          in   1          asynchronous, active-high reset
//  in_valid     in   1          upstream presents a command
//  in_ready     out  1          stage can accept this cycle
//  in_cmd       in   alu_cmd_t  ADD/SUB/AND/OR/NONE from ALU controller
//  in_a         in   WIDTH      operand A (rs)
//  in_b         in   WIDTH      operand B (rt or extended immediate)
//  in_rd        in   5          destination register index
//  out_valid    out  1          result available
//  out_ready    in   1          downstream consumes result
//  out_result   out  WIDTH      computed value (wrapped on overflow)
//  out_rd       out  5          destination index, carried with result
//  out_zero     out  1          out_result == 0
//  out_ovf      out  1          signed overflow (ADD/SUB only)
//  out_illegal  out  1          cmd was NONE
//  out_wb_en    out  1          !ovf && !illegal && rd != 0
//  stat_ops     out  CNT_WIDTH  accepted commands, saturating
//  stat_ovf     out  CNT_WIDTH  accepted commands with ovf, saturating
// BEHAVIOUR
//  - Reset (async, immediate):
//    - both buffer entries empty; out_valid=0; in_ready=1.
//    - out_result/out_rd/flags=0; stat_ops=stat_ovf=0.
//  - Accept = in_valid && in_ready. Transfer = out_valid && out_ready.
//  - Latency: a command accepted in cycle N is on the outputs with out_valid=1 in cycle N+1 if the main entry is free.
//  - Arithmetic, all WIDTH bits, two's complement:
//    - ADD a+b; SUB a-b; AND a&b; OR a|b; NONE result=0.
//    - ADD ovf = sign(a)==sign(b) && sign(res)!=sign(a).
//    - SUB ovf = sign(a)!=sign(b) && sign(res)!=sign(a).
//    - ovf=0 for AND/OR/NONE. zero is computed on the stored result.
//  - Buffer: main entry M drives outputs; skid entry S.
//    - in_ready = !S.full, a registered value with no combinational path from out_ready.
//    - accept, M empty or transferring, S empty -> new result into M.
//    - accept, M full and not transferring -> new result into S.
//    - transfer with S full -> S moves to M; S empty.
//    - simultaneous transfer and accept with S full is impossible (in_ready=0).
//    - order strictly FIFO; outputs held stable while out_valid && !out_ready.
//  - Counters:
//    - stat_ops += 1 per accept; stat_ovf += 1 per accept with ovf.
//    - both saturate at all-ones and never wrap.
//  - Reset mid-operation discards buffered results with no partial output.
//  - in_* values are ignored when in_valid=0 or in_ready=0.
// TESTING
//  - Reset: assert rst mid-stream with 2 entries held
//    -> next cycle out_valid=0, in_ready=1, stats=0.
//  - ADD 0x7FFFFFFF+0x00000001, rd=3, out_ready=1
//    -> N+1 result=0x80000000, ovf=1, wb_en=0, stat_ovf=1.
//  - SUB 5-5, rd=0
//    -> result=0, zero=1, ovf=0, wb_en=0 (rd=0).
//  - Backpressure: out_ready=0, send AND 0xF0F0&0xFF00 then OR 0x1|0x2
//    -> in_ready drops to 0 after the 2nd accept; out holds 0xF000.
//    -> raise out_ready: results 0xF000 then 0x3 in order; in_ready=1 again.
//  - cmd=NONE, a=0x1234, rd=4 -> result=0, illegal=1, zero=1, wb_en=0.
//  - CNT_WIDTH=2: 5 accepted ops -> stat_ops stays 3 and does not wrap.

Source files
------------

// File: rtl/ALUType.sv
// Command encoding shared between the ALU controller and the execute stage.
package ALUType;
  typedef enum logic [2:0] {
    ALU_ADD  = 3'd0,
    ALU_SUB  = 3'd1,
    ALU_AND  = 3'd2,
    ALU_OR   = 3'd3,
    ALU_NONE = 3'd4
  } alu_cmd_t;
endpackage

// File: rtl/alu_exec_stage.sv
// ALU execute stage: ADD/SUB/AND/OR with zero/ovf/illegal flags, one-cycle latency to a registered output.
// Two-entry skid buffer; in_ready is registered (skid not full), so no combinational path from out_ready.
module alu_exec_stage
  import ALUType::*;
#(
  parameter int WIDTH     = 32,
  parameter int CNT_WIDTH = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  alu_cmd_t             in_cmd,
  input  logic [WIDTH-1:0]     in_a,
  input  logic [WIDTH-1:0]     in_b,
  input  logic [4:0]           in_rd,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [WIDTH-1:0]     out_result,
  output logic [4:0]           out_rd,
  output logic                 out_zero,
  output logic                 out_ovf,
  output logic                 out_illegal,
  output logic                 out_wb_en,
  output logic [CNT_WIDTH-1:0] stat_ops,
  output logic [CNT_WIDTH-1:0] stat_ovf
);

  typedef struct packed {
    logic [WIDTH-1:0] result;
    logic [4:0]       rd;
    logic             zero;
    logic             ovf;
    logic             illegal;
  } entry_t;

  localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);
  localparam logic [CNT_WIDTH-1:0] CNT_MAX = '1;

  entry_t               w_new;
  entry_t               r_m;
  entry_t               r_s;
  logic                 r_m_vld;
  logic                 r_s_vld;
  logic [WIDTH-1:0]     w_sum;
  logic [WIDTH-1:0]     w_diff;
  logic                 w_accept;
  logic                 w_xfer;
  logic                 w_m_free;
  logic [CNT_WIDTH-1:0] r_stat_ops;
  logic [CNT_WIDTH-1:0] r_stat_ovf;

  always_comb begin
    w_new        = '0;
    w_sum        = in_a + in_b;
    w_diff       = in_a - in_b;
    w_new.rd     = in_rd;
    case (in_cmd)
      ALU_ADD: begin
        w_new.result = w_sum;
        w_new.ovf    = (in_a[WIDTH-1] == in_b[WIDTH-1]) && (w_sum[WIDTH-1] != in_a[WIDTH-1]);
      end
      ALU_SUB: begin
        w_new.result = w_diff;
        w_new.ovf    = (in_a[WIDTH-1] != in_b[WIDTH-1]) && (w_diff[WIDTH-1] != in_a[WIDTH-1]);
      end
      ALU_AND: w_new.result = in_a & in_b;
      ALU_OR:  w_new.result = in_a | in_b;
      // NONE and unused encodings both flag the command as illegal
      default: w_new.illegal = 1'b1;
    endcase
    w_new.zero = (w_new.result == '0);
  end

  assign w_accept = in_valid && !r_s_vld;
  assign w_xfer   = r_m_vld && out_ready;
  assign w_m_free = !r_m_vld || w_xfer;

  // A full skid entry always refills main first, which keeps the stream in order
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_m     <= '0;
      r_s     <= '0;
      r_m_vld <= 1'b0;
      r_s_vld <= 1'b0;
    end else if (w_m_free) begin
      if (r_s_vld) begin
        r_m     <= r_s;
        r_m_vld <= 1'b1;
        r_s_vld <= 1'b0;
      end else if (w_accept) begin
        r_m     <= w_new;
        r_m_vld <= 1'b1;
      end else begin
        r_m_vld <= 1'b0;
      end
    end else if (w_accept) begin
      r_s     <= w_new;
      r_s_vld <= 1'b1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stat_ops <= '0;
      r_stat_ovf <= '0;
    end else begin
      if (w_accept && (r_stat_ops != CNT_MAX)) r_stat_ops <= r_stat_ops + CNT_ONE;
      if (w_accept && w_new.ovf && (r_stat_ovf != CNT_MAX)) r_stat_ovf <= r_stat_ovf + CNT_ONE;
    end
  end

  assign in_ready    = !r_s_vld;
  assign out_valid   = r_m_vld;
  assign out_result  = r_m.result;
  assign out_rd      = r_m.rd;
  assign out_zero    = r_m.zero;
  assign out_ovf     = r_m.ovf;
  assign out_illegal = r_m.illegal;
  assign out_wb_en   = !r_m.ovf && !r_m.illegal && (r_m.rd != 5'd0);
  assign stat_ops    = r_stat_ops;
  assign stat_ovf    = r_stat_ovf;

endmodule

// File: tb/tb_alu_exec_stage.sv
// Self-checking bench for alu_exec_stage: vector table, hand-written corner sequences, random stream vs queue model.
module tb_alu_exec_stage;
  import ALUType::*;

  localparam longint MAXP = 64'sd2147483647;
  localparam longint MINN = -64'sd2147483648;

  logic        clk;
  logic        rst;
  logic        in_valid, in_ready, out_valid, out_ready;
  alu_cmd_t    in_cmd;
  logic [31:0] in_a, in_b, out_result;
  logic [4:0]  in_rd, out_rd;
  logic        out_zero, out_ovf, out_illegal, out_wb_en;
  logic [15:0] stat_ops, stat_ovf;

  logic        s_in_valid, s_in_ready, s_out_valid, s_out_ready;
  alu_cmd_t    s_in_cmd;
  logic [31:0] s_in_a, s_in_b, s_out_result;
  logic [4:0]  s_in_rd, s_out_rd;
  logic        s_out_zero, s_out_ovf, s_out_illegal, s_out_wb_en;
  logic [1:0]  s_stat_ops, s_stat_ovf;

  int n_chk  = 0;
  int n_fail = 0;

  alu_exec_stage #(.WIDTH(32), .CNT_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_cmd(in_cmd),
    .in_a(in_a), .in_b(in_b), .in_rd(in_rd), .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_rd(out_rd), .out_zero(out_zero), .out_ovf(out_ovf),
    .out_illegal(out_illegal), .out_wb_en(out_wb_en), .stat_ops(stat_ops), .stat_ovf(stat_ovf)
  );

  alu_exec_stage #(.WIDTH(32), .CNT_WIDTH(2)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(s_in_valid), .in_ready(s_in_ready), .in_cmd(s_in_cmd),
    .in_a(s_in_a), .in_b(s_in_b), .in_rd(s_in_rd), .out_valid(s_out_valid), .out_ready(s_out_ready),
    .out_result(s_out_result), .out_rd(s_out_rd), .out_zero(s_out_zero), .out_ovf(s_out_ovf),
    .out_illegal(s_out_illegal), .out_wb_en(s_out_wb_en), .stat_ops(s_stat_ops), .stat_ovf(s_stat_ovf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  typedef struct {
    logic [31:0] result;
    logic [4:0]  rd;
    logic        zero;
    logic        ovf;
    logic        ill;
    logic        wb;
  } exp_t;

  typedef struct {
    alu_cmd_t    cmd;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  rd;
    logic [31:0] e_res;
    logic        e_zero;
    logic        e_ovf;
    logic        e_ill;
    logic        e_wb;
  } vec_t;

  exp_t q[$];
  int   m_ops;
  int   m_ovf;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
    n_chk++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, req, $time);
    end
  endtask

  // Signed overflow judged by whether the exact integer result fits in 32 bits
  function automatic exp_t ref_model(alu_cmd_t c, logic [31:0] a, logic [31:0] b, logic [4:0] rd);
    exp_t   m;
    longint sa, sb, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    m.result = 32'd0;
    m.ovf    = 1'b0;
    m.ill    = 1'b0;
    m.rd     = rd;
    case (c)
      ALU_ADD: begin r = sa + sb; m.result = r[31:0]; m.ovf = (r > MAXP) || (r < MINN); end
      ALU_SUB: begin r = sa - sb; m.result = r[31:0]; m.ovf = (r > MAXP) || (r < MINN); end
      ALU_AND: m.result = a & b;
      ALU_OR:  m.result = a | b;
      default: m.ill = 1'b1;
    endcase
    m.zero = (m.result == 32'd0);
    m.wb   = !m.ovf && !m.ill && (rd != 5'd0);
    return m;
  endfunction

  task automatic check_outputs();
    chk("out_valid", out_valid, q.size() > 0);
    chk("in_ready", in_ready, q.size() < 2);
    if (q.size() > 0) begin
      chk("result", out_result, q[0].result);
      chk("rd", out_rd, q[0].rd);
      chk("zero", out_zero, q[0].zero);
      chk("ovf", out_ovf, q[0].ovf);
      chk("illegal", out_illegal, q[0].ill);
      chk("wb_en", out_wb_en, q[0].wb);
    end
    chk("stat_ops", stat_ops, m_ops);
    chk("stat_ovf", stat_ovf, m_ovf);
  endtask

  // Called just after a falling edge: drive, advance the model, clock once, check.
  task automatic cycle(input logic v, input alu_cmd_t c, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] rd, input logic ordy);
    bit   acc, xf;
    exp_t e;
    in_valid  = v;
    in_cmd    = c;
    in_a      = a;
    in_b      = b;
    in_rd     = rd;
    out_ready = ordy;
    acc = v && (q.size() < 2);
    xf  = (q.size() > 0) && ordy;
    if (xf) void'(q.pop_front());
    if (acc) begin
      e = ref_model(c, a, b, rd);
      q.push_back(e);
      if (m_ops < 65535) m_ops++;
      if (e.ovf && m_ovf < 65535) m_ovf++;
    end
    @(negedge clk);
    check_outputs();
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 5))
      0: return 32'h0000_0000;
      1: return 32'h7FFF_FFFF;
      2: return 32'h8000_0000;
      3: return 32'hFFFF_FFFF;
      default: return $urandom;
    endcase
  endfunction

  vec_t        tbl[8];
  logic [2:0]  rc;
  int          exp_sat;

  initial begin
    tbl[0] = '{ALU_ADD,  32'h7FFF_FFFF, 32'h0000_0001, 5'd3, 32'h8000_0000, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[1] = '{ALU_SUB,  32'h0000_0005, 32'h0000_0005, 5'd0, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b0};
    tbl[2] = '{ALU_NONE, 32'h0000_1234, 32'h0000_0000, 5'd4, 32'h0000_0000, 1'b1, 1'b0, 1'b1, 1'b0};
    tbl[3] = '{ALU_AND,  32'h0000_F0F0, 32'h0000_FF00, 5'd1, 32'h0000_F000, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[4] = '{ALU_OR,   32'h0000_0001, 32'h0000_0002, 5'd2, 32'h0000_0003, 1'b0, 1'b0, 1'b0, 1'b1};
    tbl[5] = '{ALU_SUB,  32'h8000_0000, 32'h0000_0001, 5'd5, 32'h7FFF_FFFF, 1'b0, 1'b1, 1'b0, 1'b0};
    tbl[6] = '{ALU_ADD,  32'hFFFF_FFFF, 32'h0000_0001, 5'd6, 32'h0000_0000, 1'b1, 1'b0, 1'b0, 1'b1};
    tbl[7] = '{ALU_SUB,  32'h0000_0003, 32'h0000_0005, 5'd7, 32'hFFFF_FFFE, 1'b0, 1'b0, 1'b0, 1'b1};

    rst = 1'b1;
    in_valid = 1'b0; in_cmd = ALU_NONE; in_a = '0; in_b = '0; in_rd = '0; out_ready = 1'b0;
    s_in_valid = 1'b0; s_in_cmd = ALU_ADD; s_in_a = 32'h7FFF_FFFF; s_in_b = 32'h1; s_in_rd = 5'd1;
    s_out_ready = 1'b1;
    m_ops = 0; m_ovf = 0;

    #1;
    chk("reset_out_valid", out_valid, 1'b0);
    chk("reset_in_ready", in_ready, 1'b1);
    chk("reset_result", out_result, 32'h0);
    chk("reset_flags", {out_zero, out_ovf, out_illegal, out_wb_en, out_rd}, 9'h0);
    chk("reset_stats", {stat_ops, stat_ovf}, 32'h0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;

    // Vector table, one command per cycle with the sink always ready
    for (int i = 0; i < 8; i++) begin
      cycle(1'b1, tbl[i].cmd, tbl[i].a, tbl[i].b, tbl[i].rd, 1'b1);
      chk($sformatf("tbl%0d_valid", i), out_valid, 1'b1);
      chk($sformatf("tbl%0d_result", i), out_result, tbl[i].e_res);
      chk($sformatf("tbl%0d_flags", i), {out_zero, out_ovf, out_illegal, out_wb_en},
          {tbl[i].e_zero, tbl[i].e_ovf, tbl[i].e_ill, tbl[i].e_wb});
      chk($sformatf("tbl%0d_rd", i), out_rd, tbl[i].rd);
      if (i == 0) chk("tbl0_stat_ovf", stat_ovf, 16'd1);
    end
    cycle(1'b0, ALU_NONE, '0, '0, '0, 1'b1);
    chk("drain_empty", out_valid, 1'b0);

    // Backpressure: two results pile up, third command must be ignored
    cycle(1'b1, ALU_AND, 32'h0000_F0F0, 32'h0000_FF00, 5'd8, 1'b0);
    chk("bp_first_in_ready", in_ready, 1'b1);
    cycle(1'b1, ALU_OR, 32'h1, 32'h2, 5'd9, 1'b0);
    chk("bp_in_ready_low", in_ready, 1'b0);
    chk("bp_hold_f000", out_result, 32'h0000_F000);
    cycle(1'b1, ALU_ADD, 32'hDEAD_BEEF, 32'h1, 5'd10, 1'b0);
    chk("bp_still_f000", out_result, 32'h0000_F000);
    chk("bp_ignored_ops", stat_ops, 16'd10);
    cycle(1'b0, ALU_NONE, '0, '0, '0, 1'b1);
    chk("bp_second_out", out_result, 32'h0000_0003);
    chk("bp_in_ready_back", in_ready, 1'b1);
    cycle(1'b0, ALU_NONE, '0, '0, '0, 1'b1);
    chk("bp_empty", out_valid, 1'b0);

    // Reset with both entries held
    cycle(1'b1, ALU_ADD, 32'h10, 32'h20, 5'd11, 1'b0);
    cycle(1'b1, ALU_SUB, 32'h10, 32'h20, 5'd12, 1'b0);
    chk("pre_rst_full", in_ready, 1'b0);
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", out_valid, 1'b0);
    chk("mid_rst_in_ready", in_ready, 1'b1);
    chk("mid_rst_stats", {stat_ops, stat_ovf}, 32'h0);
    q.delete();
    m_ops = 0;
    m_ovf = 0;
    @(negedge clk);
    rst = 1'b0;
    cycle(1'b0, ALU_NONE, '0, '0, '0, 1'b1);
    chk("post_rst_idle", out_valid, 1'b0);

    // Random stream with random backpressure against the queue model
    for (int i = 0; i < 400; i++) begin
      rc = 3'($urandom_range(0, 4));
      cycle($urandom_range(0, 3) != 0, alu_cmd_t'(rc), pick(), pick(), 5'($urandom_range(0, 31)),
            $urandom_range(0, 2) != 0);
    end
    for (int i = 0; i < 3; i++) cycle(1'b0, ALU_NONE, '0, '0, '0, 1'b1);

    // 2-bit counters: five overflowing accepts saturate both at 3
    s_in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      exp_sat = (i + 1 < 3) ? i + 1 : 3;
      chk($sformatf("sat_ops_%0d", i), s_stat_ops, exp_sat);
      chk($sformatf("sat_ovf_%0d", i), s_stat_ovf, exp_sat);
    end
    s_in_valid = 1'b0;
    @(negedge clk);
    chk("sat_ops_final", s_stat_ops, 2'd3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
